// File: rtl/dpctrl_pkg.sv
// Shared types and encodings for the datapath instruction controller.
package dpctrl_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_COMPUTE,
    S_WRITE_REG,
    S_WRITE_IMM,
    S_HALT
  } state_e;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // MOV sub-ops live in the same op field as the ALU ops.
  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] VSEL_MDATA = 2'b00;
  localparam logic [1:0] VSEL_IMM8  = 2'b01;
  localparam logic [1:0] VSEL_PC    = 2'b10;
  localparam logic [1:0] VSEL_C     = 2'b11;

  // Field order matches IR[15:0] so the IR can be assigned directly.
  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
  } ir_fields_t;

endpackage

// File: rtl/dpctrl_decode.sv
// Combinational IR field split, immediate sign extension and legality flag.
module dpctrl_decode
  import dpctrl_pkg::*;
(
  input  logic [15:0] i_ir,
  output ir_fields_t  o_fields,
  output logic [15:0] o_sximm8,
  output logic [15:0] o_sximm5,
  output logic        o_legal
);

  ir_fields_t w_f;

  assign w_f      = i_ir;
  assign o_fields = w_f;
  assign o_sximm8 = {{8{i_ir[7]}}, i_ir[7:0]};
  assign o_sximm5 = {{11{i_ir[4]}}, i_ir[4:0]};

  // Every ALU op is defined; only two of the four MOV sub-ops are.
  assign o_legal = (w_f.opcode == OPC_ALU) ||
                   ((w_f.opcode == OPC_MOV) && ((w_f.op == MOV_IMM) || (w_f.op == MOV_REG)));

endmodule

// File: rtl/datapath_ctrl.sv
// Instruction controller: IR latch plus Moore FSM sequencing datapath strobes.
// Optional DPCTRL_ILLEGAL_TRAP_EN adds the illegal port and a sticky HALT state.
module datapath_ctrl
  import dpctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [1:0]  vsel,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
`ifdef DPCTRL_ILLEGAL_TRAP_EN
  ,
  output logic        illegal
`endif
);

  state_e     r_state;
  state_e     w_next_state;
  logic [15:0] r_ir;
  ir_fields_t w_f;
  logic       w_legal;

  dpctrl_decode u_decode (
    .i_ir     (r_ir),
    .o_fields (w_f),
    .o_sximm8 (sximm8),
    .o_sximm5 (sximm5),
    .o_legal  (w_legal)
  );

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == S_WAIT) && load) r_ir <= in;
    end
  end

  // NOTE: the default at the top of each always_comb prevents latch inference.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_WAIT:      if (s) w_next_state = S_DECODE;
      S_DECODE: begin
        if (!w_legal)
`ifdef DPCTRL_ILLEGAL_TRAP_EN
          w_next_state = S_HALT;
`else
          w_next_state = S_WAIT;
`endif
        else if (w_f.opcode == OPC_MOV)
          w_next_state = (w_f.op == MOV_IMM) ? S_WRITE_IMM : S_GET_B;
        else if (w_f.op == ALU_MVN)
          w_next_state = S_GET_B;
        else
          w_next_state = S_GET_A;
      end
      S_GET_A:     w_next_state = S_GET_B;
      S_GET_B:     w_next_state = S_COMPUTE;
      S_COMPUTE:   w_next_state = ((w_f.opcode == OPC_ALU) && (w_f.op == ALU_CMP)) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: w_next_state = S_WAIT;
      S_WRITE_IMM: w_next_state = S_WAIT;
`ifdef DPCTRL_ILLEGAL_TRAP_EN
      S_HALT:      w_next_state = S_HALT;
`endif
      default:     w_next_state = S_WAIT;
    endcase
  end

  always_comb begin
    w        = 1'b0;
    readnum  = '0;
    writenum = '0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    write    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = '0;
    ALUop    = '0;
    vsel     = '0;
`ifdef DPCTRL_ILLEGAL_TRAP_EN
    illegal  = 1'b0;
`endif
    case (r_state)
      S_WAIT:  w = 1'b1;
      S_GET_A: begin
        readnum = w_f.rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = w_f.rm;
        loadb   = 1'b1;
      end
      S_COMPUTE: begin
        shift = w_f.sh;
        loadc = 1'b1;
        // Only MOV-reg reaches COMPUTE with the MOV opcode; it passes B through like MVN.
        if (w_f.opcode == OPC_ALU) begin
          ALUop = w_f.op;
          loads = 1'b1;
          asel  = (w_f.op == ALU_MVN);
        end else begin
          asel  = 1'b1;
        end
      end
      S_WRITE_REG: begin
        vsel     = VSEL_C;
        writenum = w_f.rd;
        write    = 1'b1;
      end
      S_WRITE_IMM: begin
        vsel     = VSEL_IMM8;
        writenum = w_f.rn;
        write    = 1'b1;
      end
`ifdef DPCTRL_ILLEGAL_TRAP_EN
      S_HALT:  illegal = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Self-checking bench for datapath_ctrl: directed cases plus randomized instructions
// compared cycle by cycle against an instruction-level reference model.
module tb_datapath_ctrl;

  typedef logic [20:0] vec_t;

`ifdef DPCTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, load, s;
  logic [15:0] in;
  logic        w, loada, loadb, loadc, loads, write, asel, bsel, illegal;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop, vsel;
  logic [15:0] sximm8, sximm5;

  int   checks   = 0;
  int   failures = 0;
  vec_t exp_q[$];
  vec_t wait_v;
  vec_t halt_v;

  always #5 clk = ~clk;

  datapath_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .load     (load),
    .s        (s),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .write    (write),
    .asel     (asel),
    .bsel     (bsel),
    .shift    (shift),
    .ALUop    (ALUop),
    .vsel     (vsel),
    .sximm8   (sximm8),
    .sximm5   (sximm5)
`ifdef DPCTRL_ILLEGAL_TRAP_EN
    ,
    .illegal  (illegal)
`endif
  );

`ifndef DPCTRL_ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

  function automatic vec_t pack_out(input logic il, input logic wv, input logic [2:0] rdn,
                                    input logic la, input logic lb, input logic asl,
                                    input logic bs, input logic [1:0] sh, input logic [1:0] alu,
                                    input logic lc, input logic ls, input logic [1:0] vs,
                                    input logic [2:0] wn, input logic wr);
    return {il, wv, rdn, la, lb, asl, bs, sh, alu, lc, ls, vs, wn, wr};
  endfunction

  function automatic vec_t dut_vec();
    return {illegal, w, readnum, loada, loadb, asel, bsel, shift, ALUop,
            loadc, loads, vsel, writenum, write};
  endfunction

  // Expected outputs observed after each clock edge following the start edge.
  function automatic void build_model(input logic [15:0] ir);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    logic       mov_imm, mov_reg, alu;
    opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8];
    rd  = ir[7:5];   sh = ir[4:3];   rm = ir[2:0];
    mov_imm = (opc == 3'b110) && (op == 2'b10);
    mov_reg = (opc == 3'b110) && (op == 2'b00);
    alu     = (opc == 3'b101);
    exp_q.delete();
    exp_q.push_back(pack_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (mov_imm) begin
      exp_q.push_back(pack_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, rn, 1));
    end else if (mov_reg || alu) begin
      if (alu && op != 2'b11)
        exp_q.push_back(pack_out(0, 0, rn, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(pack_out(0, 0, rm, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(pack_out(0, 0, 0, 0, 0, mov_reg || (op == 2'b11), 0, sh,
                               alu ? op : 2'b00, 1, alu, 0, 0, 0));
      if (!(alu && op == 2'b01))
        exp_q.push_back(pack_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, rd, 1));
    end
    if (!(mov_imm || mov_reg || alu) && TRAP) exp_q.push_back(halt_v);
    else                                      exp_q.push_back(wait_v);
  endfunction

  task automatic start(input logic [15:0] ir, input bit hold_s);
    @(negedge clk);
    in = ir; load = 1'b1; s = 1'b1;
    @(negedge clk);
    load = 1'b0;
    if (!hold_s) s = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; s = 1'b0; load = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; load = 1'b1; in = 16'hFFFF; s = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dut_vec() !== wait_v) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected %h", dut_vec(), wait_v);
    end
    checks++;
    if (sximm8 !== 16'h0000 || sximm5 !== 16'h0000) begin
      failures++;
      $display("FAIL reset_imm: got sximm8=%h sximm5=%h expected 0000 0000", sximm8, sximm5);
    end
    reset = 1'b0; load = 1'b0; s = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] irs[5]  = '{16'hD007, 16'hD1FE, 16'hA148, 16'hA900, 16'hB860};
    int          lats[5] = '{3, 3, 6, 5, 5};
    logic [15:0] imm8[5] = '{16'h0007, 16'hFFFE, 16'h0048, 16'h0000, 16'h0060};
    int lat;
    for (int k = 0; k < 5; k++) begin
      build_model(irs[k]);
      start(irs[k], 1'b0);
      lat = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) @(negedge clk);
        if (w && lat == 0) lat = i + 1;
        checks++;
        if (dut_vec() !== exp_q[i]) begin
          failures++;
          $display("FAIL directed_%h step %0d: got %h expected %h", irs[k], i, dut_vec(), exp_q[i]);
        end
        if (i == 0) begin
          checks++;
          if (sximm8 !== imm8[k]) begin
            failures++;
            $display("FAIL directed_%h sximm8: got %h expected %h", irs[k], sximm8, imm8[k]);
          end
        end
      end
      checks++;
      if (lat !== lats[k]) begin
        failures++;
        $display("FAIL directed_%h latency: got %0d expected %0d", irs[k], lat, lats[k]);
      end
    end
  endtask

  task automatic test_load_only();
    @(negedge clk);
    in = 16'hD005; load = 1'b1; s = 1'b0;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_vec() !== wait_v || sximm8 !== 16'h0005) begin
      failures++;
      $display("FAIL load_only: got vec=%h sximm8=%h expected %h 0005", dut_vec(), sximm8, wait_v);
    end
  endtask

  task automatic test_random();
    logic [15:0] ir;
    logic signed [7:0] b8;
    logic signed [4:0] b5;
    int kind;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 5);
      ir[10:0] = 11'($urandom);
      case (kind)
        0:       ir[15:11] = 5'b11010;
        1:       ir[15:11] = 5'b11000;
        default: ir[15:11] = {3'b101, 2'(kind - 2)};
      endcase
      b8 = ir[7:0];
      b5 = ir[4:0];
      build_model(ir);
      start(ir, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) @(negedge clk);
        checks++;
        if (dut_vec() !== exp_q[i]) begin
          failures++;
          $display("FAIL random_%h step %0d: got %h expected %h", ir, i, dut_vec(), exp_q[i]);
        end
        if (i == 0) begin
          checks++;
          if (sximm8 !== 16'(b8) || sximm5 !== 16'(b5)) begin
            failures++;
            $display("FAIL random_%h imm: got %h %h expected %h %h", ir, sximm8, sximm5, 16'(b8), 16'(b5));
          end
        end
        // Loads outside WAIT must not disturb the instruction in flight.
        if (i < exp_q.size() - 1) begin
          load = 1'($urandom);
          in   = 16'($urandom);
        end else begin
          load = 1'b0;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    build_model(16'hB860);
    start(16'hB860, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (dut_vec() !== exp_q[i]) begin
        failures++;
        $display("FAIL back_to_back_first step %0d: got %h expected %h", i, dut_vec(), exp_q[i]);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      s = 1'b0;
      checks++;
      if (dut_vec() !== exp_q[i]) begin
        failures++;
        $display("FAIL back_to_back_repeat step %0d: got %h expected %h", i, dut_vec(), exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    build_model(16'hA148);
    start(16'hA148, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (dut_vec() !== exp_q[i]) begin
        failures++;
        $display("FAIL reset_mid step %0d: got %h expected %h", i, dut_vec(), exp_q[i]);
      end
      if (i == 1) begin load = 1'b1; in = 16'hD0FF; end
      if (i == 2) load = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (dut_vec() !== wait_v || sximm8 !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mid_abort: got vec=%h sximm8=%h expected %h 0000", dut_vec(), sximm8, wait_v);
    end
    @(negedge clk);
    checks++;
    if (dut_vec() !== wait_v) begin
      failures++;
      $display("FAIL reset_mid_idle: got %h expected %h", dut_vec(), wait_v);
    end
  endtask

  task automatic test_illegal();
    logic [15:0] irs[3] = '{16'h0000, 16'hE123, 16'hD812};
    for (int k = 0; k < 3; k++) begin
      build_model(irs[k]);
      start(irs[k], 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) @(negedge clk);
        checks++;
        if (dut_vec() !== exp_q[i]) begin
          failures++;
          $display("FAIL illegal_%h step %0d: got %h expected %h", irs[k], i, dut_vec(), exp_q[i]);
        end
      end
`ifdef DPCTRL_ILLEGAL_TRAP_EN
      s = 1'b1;
      repeat (3) begin
        @(negedge clk);
        checks++;
        if (dut_vec() !== halt_v) begin
          failures++;
          $display("FAIL illegal_%h hold: got %h expected %h", irs[k], dut_vec(), halt_v);
        end
      end
      apply_reset();
      checks++;
      if (dut_vec() !== wait_v) begin
        failures++;
        $display("FAIL illegal_%h release: got %h expected %h", irs[k], dut_vec(), wait_v);
      end
`else
      @(negedge clk);
      checks++;
      if (dut_vec() !== wait_v) begin
        failures++;
        $display("FAIL illegal_%h idle: got %h expected %h", irs[k], dut_vec(), wait_v);
      end
`endif
    end
  endtask

  initial begin
    wait_v = pack_out(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    halt_v = pack_out(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1; load = 1'b0; s = 1'b0; in = 16'h0000;
    test_reset();
    test_directed();
    test_load_only();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
Instruction-level controller for the register-file/shifter/ALU datapath. It latches one 16-bit instruction, decodes it, and sequences the datapath control strobes (readnum, loada, loadb, asel, bsel, shift, ALUop, loadc, loads, vsel, writenum, write) one state per clock. It also produces sximm8 and sximm5 for the datapath. It sits between the instruction source and the datapath and handles one instruction at a time, with start/wait handshaking.

Parameters:
None. Widths are fixed by the instruction set: 16-bit data, 3-bit register index, 2-bit ALUop/shift/vsel.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high; returns the FSM to WAIT and clears the IR
in  in  16  instruction word
load  in  1  capture `in` into the IR (honoured only in WAIT)
s  in  1  start; sampled only in WAIT
w  out  1  high only in WAIT (ready for the next instruction)
readnum, writenum  out  3 each  register file indices
loada, loadb, loadc, loads, write  out  1 each  datapath load/write strobes
asel, bsel  out  1 each  datapath source selects
shift  out  2  shifter op
ALUop  out  2  ALU op
vsel  out  2  writeback select: 00 mdata, 01 sximm8, 10 PC, 11 C
sximm8  out  16  sign-extended IR[7:0]
sximm5  out  16  sign-extended IR[4:0]
illegal  out  1  present only with DPCTRL_ILLEGAL_TRAP_EN

Behaviour:
- IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- Supported instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{,sh}
  - 101/00 ADD Rd,Rn,Rm{,sh}
  - 101/01 CMP Rn,Rm{,sh}
  - 101/10 AND Rd,Rn,Rm{,sh}
  - 101/11 MVN Rd,Rm{,sh}
  - All other encodings are illegal.
- Moore outputs: every output is a function of the state register and IR only. All strobes, selects and indices are 0 except where listed below.
- States and outputs:
  - WAIT: w=1.
  - DECODE: no strobes.
  - GET_A: readnum=Rn, loada=1.
  - GET_B: readnum=Rm, loadb=1.
  - COMPUTE:
    - shift=sh, bsel=0, loadc=1.
    - ALUop=op for opcode 101; ALUop=00 for MOV-reg.
    - asel=1 for MOV-reg and MVN, else 0.
    - loads=1 for opcode 101 only.
  - WRITE_REG: vsel=11, writenum=Rd, write=1.
  - WRITE_IMM: vsel=01, writenum=Rn, write=1.
- Transitions:
  - WAIT -> DECODE when s=1, else stay.
  - DECODE -> WRITE_IMM for MOV-imm.
  - DECODE -> GET_B for MOV-reg and MVN.
  - DECODE -> GET_A for ADD, CMP, AND.
  - DECODE -> WAIT for illegal encodings (feature off).
  - GET_A -> GET_B -> COMPUTE.
  - COMPUTE -> WAIT for CMP; COMPUTE -> WRITE_REG otherwise.
  - WRITE_REG -> WAIT; WRITE_IMM -> WAIT.
- Latency, counted from the edge that samples s to the edge at which w is high again: MOV-imm 3, MOV-reg/MVN 5, CMP 5, ADD/AND 6.
- IR load:
  - load=1 in WAIT captures `in` at that edge.
  - load and s in the same WAIT cycle: the new IR is used by DECODE.
  - load outside WAIT is ignored, so the IR is stable for the whole instruction.
- s is level-sensitive. If s is still high on return to WAIT, the same IR re-executes one cycle later.
- sximm8 and sximm5 are combinational sign extensions of the IR, valid in all states.
- Reset:
  - After the reset edge: state=WAIT, IR=0, w=1, all other outputs 0 (sximm8=sximm5=0, illegal=0).
  - Reset mid-instruction aborts it. No write occurs in the cycle after the reset edge.

Optional Feature:
DPCTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Port `illegal` exists.
  - An illegal encoding moves DECODE -> HALT.
  - In HALT: w=0, illegal=1, all strobes 0. HALT is left only by reset.
- Undefined:
  - No `illegal` port and no HALT state.
  - An illegal encoding goes DECODE -> WAIT with no strobes asserted.

Decomposition:
- Package dpctrl_pkg holds:
  - state enum (WAIT, DECODE, GET_A, GET_B, COMPUTE, WRITE_REG, WRITE_IMM, HALT)
  - opcode constants (OPC_MOV=3'b110, OPC_ALU=3'b101)
  - ALUop constants (ADD=00, CMP=01, AND=10, MVN=11)
  - vsel constants (VSEL_MDATA=00, VSEL_IMM8=01, VSEL_PC=10, VSEL_C=11)
- One sub-module, dpctrl_decode: combinational IR field extraction, sign extension and legal-opcode flag. The FSM stays in datapath_ctrl.

Test Plan:
- Reset, then load in=16'hD007 (MOV R0,#7) with s=1 -> third-state cycle shows write=1, writenum=0, vsel=01, sximm8=16'h0007; w=1 three edges after start.
- in=16'hD1FE (MOV R1,#-2) -> sximm8=16'hFFFE, writenum=1, write for exactly one cycle.
- in=16'hA148 (ADD R2,R1,R0,LSL#1) -> strobe sequence:
  - GET_A: readnum=1, loada.
  - GET_B: readnum=0, loadb.
  - COMPUTE: shift=01, ALUop=00, asel=0, loadc, loads.
  - WRITE_REG: writenum=2, vsel=11, write.
  - w back after 6 edges.
- in=16'hA900 (CMP R1,R0) and 16'hB860 (MVN R3,R0):
  - CMP: loads=1, write never asserted, 5 edges.
  - MVN: GET_A skipped; COMPUTE shows asel=1, ALUop=11; writenum=3.
- Assert reset during COMPUTE of ADD, and toggle load mid-instruction -> next state WAIT, w=1, no write; the IR ignores load outside WAIT.
- in=16'h0000 (illegal):
  - With macro: illegal=1, w=0, held until reset.
  - Without macro: back to WAIT after DECODE, all strobes 0.
